// File: rtl/rr_share_arbiter.sv
// Round-robin arbiter that funnels N valid/ready requesters into one registered
// result channel, tagging each accepted word with the index of its requester.
module rr_share_arbiter #(
   parameter int N  = 4,
   parameter int DW = 4,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [IW-1:0]   out_id,
   output logic [7:0]      grant_cnt
);

   typedef enum logic {S_IDLE, S_FULL} state_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } word_t;

   state_t        state_q, state_d;
   word_t         word_q, word_d;
   logic [IW-1:0] last_q, last_d;
   logic [7:0]    cnt_q, cnt_d;

   logic [IW-1:0] winner;
   logic          anyValid;
   logic          canAccept;
   logic          accept;

   // Scan from the slot after the last winner and wrap, so the previous winner
   // is considered last and every active requester is served within N grants.
   always_comb begin
      int            idx;
      logic          found;
      logic [IW-1:0] idxW;
      winner = last_q;
      found  = 1'b0;
      idx    = 0;
      idxW   = '0;
      for (int k = 1; k <= N; k++) begin
         idx  = (int'(last_q) + k) % N;
         idxW = IW'(idx);
         if (!found && req_valid[idxW]) begin
            found  = 1'b1;
            winner = idxW;
         end
      end
   end

   // Reset also gates the handshake, so nothing is offered while rst_n is low.
   assign anyValid  = |req_valid;
   assign canAccept = (state_q == S_IDLE) || out_ready;
   assign accept    = canAccept && anyValid && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_FULL;
         S_FULL: if (out_ready && !accept) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q == S_FULL);
      req_ready = '0;
      if (accept) begin
         req_ready = N'(1) << winner;
      end
   end

   // A pop without a push leaves the last word visible; out_valid marks it stale.
   always_comb begin
      word_d = word_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      if (accept) begin
         word_d.id   = winner;
         word_d.data = req_data[int'(winner)*DW +: DW];
         last_d      = winner;
         if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         last_q <= IW'(N - 1);
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_data  = word_q.data;
   assign out_id    = word_q.id;
   assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_rr_share_arbiter.sv
// Directed bench for rr_share_arbiter (N=4, DW=4) with hand-computed
// expectations checked by immediate assertions.
module tb_rr_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_id;
   logic [7:0]  grant_cnt;

   int nAsserts = 0;
   int nFail    = 0;

   rr_share_arbiter #(.N(4), .DW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .grant_cnt (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d, input logic r);
      req_valid = v;
      req_data  = d;
      out_ready = r;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkRegs(input string tag, input logic v, input logic [3:0] d,
                            input logic [1:0] id, input logic [7:0] cnt);
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      checkOutput({tag, ".out_data"},  32'(out_data),  32'(d));
      checkOutput({tag, ".out_id"},    32'(out_id),    32'(id));
      checkOutput({tag, ".grant_cnt"}, 32'(grant_cnt), 32'(cnt));
   endtask

   initial begin
      logic [1:0] expIdB [6];
      logic [3:0] expDataB [6];
      logic [1:0] expIdW [3];

      expIdB   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      expDataB = '{4'h1, 4'h5, 4'h3, 4'h4, 4'h1, 4'h5};
      expIdW   = '{2'd1, 2'd3, 2'd1};

      // Reset held with random inputs
      rst_n = 1'b0;
      applyStimulus(4'($urandom), 16'($urandom), 1'($urandom));
      repeat (3) tick();
      checkOutput("rst_hold.req_ready", 32'(req_ready), 32'h0);
      checkRegs("rst_hold", 1'b0, 4'h0, 2'd0, 8'd0);

      applyStimulus(4'b0000, 16'h0000, 1'b1);
      rst_n = 1'b1;
      tick();
      checkOutput("rst_rel.req_ready", 32'(req_ready), 32'h0);
      checkRegs("rst_rel", 1'b0, 4'h0, 2'd0, 8'd0);

      // Single requester on lane 2
      applyStimulus(4'b0100, 16'h0A00, 1'b1);
      checkOutput("single.req_ready", 32'(req_ready), 32'b0100);
      tick();
      checkRegs("single", 1'b1, 4'hA, 2'd2, 8'd1);
      applyStimulus(4'b0000, 16'h0A00, 1'b1);
      checkOutput("single_drain.req_ready", 32'(req_ready), 32'h0);
      tick();
      checkOutput("single_drain.out_valid", 32'(out_valid), 32'h0);

      // Contention starting from last=2, then async reset mid-burst
      applyStimulus(4'b1111, 16'h4321, 1'b1);
      tick();
      checkRegs("burstA0", 1'b1, 4'h4, 2'd3, 8'd2);
      tick();
      checkRegs("burstA1", 1'b1, 4'h1, 2'd0, 8'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst.req_ready", 32'(req_ready), 32'h0);
      checkRegs("async_rst", 1'b0, 4'h0, 2'd0, 8'd0);
      tick();
      rst_n = 1'b1;

      // Full contention after reset: 0,1,2,3,0,1
      applyStimulus(4'b1111, 16'h4351, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkRegs($sformatf("burstB%0d", i), 1'b1, expDataB[i], expIdB[i], 8'(i + 1));
      end

      // Backpressure while holding id 1 / data 5
      applyStimulus(4'b1111, 16'h4351, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp%0d.req_ready", i), 32'(req_ready), 32'h0);
         tick();
         checkRegs($sformatf("bp%0d", i), 1'b1, 4'h5, 2'd1, 8'd6);
      end
      applyStimulus(4'b1111, 16'h4351, 1'b1);
      checkOutput("bp_release.req_ready", 32'(req_ready), 32'b0100);
      tick();
      checkRegs("bp_release", 1'b1, 4'h3, 2'd2, 8'd7);

      // Move pointer to 3, then wrap-around with 4'b1010
      applyStimulus(4'b1000, 16'h9876, 1'b1);
      tick();
      checkRegs("wrap_setup", 1'b1, 4'h9, 2'd3, 8'd8);
      applyStimulus(4'b1010, 16'h9876, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("wrap%0d.req_ready", i), 32'(req_ready), 32'(4'b0001 << expIdW[i]));
         tick();
         checkOutput($sformatf("wrap%0d.out_id", i), 32'(out_id), 32'(expIdW[i]));
         checkOutput($sformatf("wrap%0d.grant_cnt", i), 32'(grant_cnt), 32'(9 + i));
      end

      // Saturation: 300 continuous accepts from a count of 11
      applyStimulus(4'b1111, 16'h4321, 1'b1);
      repeat (243) tick();
      checkOutput("sat_254.grant_cnt", 32'(grant_cnt), 32'd254);
      tick();
      checkOutput("sat_255.grant_cnt", 32'(grant_cnt), 32'd255);
      repeat (56) tick();
      checkOutput("sat_hold.grant_cnt", 32'(grant_cnt), 32'd255);
      checkOutput("sat_hold.out_valid", 32'(out_valid), 32'h1);

      applyStimulus(4'b0000, 16'h0000, 1'b1);
      tick();
      checkOutput("final_drain.out_valid", 32'(out_valid), 32'h0);
      checkOutput("final_drain.grant_cnt", 32'(grant_cnt), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
